// File: rtl/axi_resp_pkg.sv
// Shared AXI response/burst codes and channel FSM state types for the burst
// memory responder.
package axi_resp_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

endpackage

// File: rtl/axi_sdp_ram.sv
// Simple dual-port RAM: byte-enabled write port, registered read port that
// holds its output while rd_en is low. Same-address read returns old data.
module axi_sdp_ram #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_BITS  = 16
) (
  input  logic                    clk,
  input  logic [ADDR_BITS-1:0]    wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    rd_en,
  input  logic [ADDR_BITS-1:0]    rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    for (int unsigned b = 0; b < DATA_WIDTH/8; b++) begin
      if (wr_strb[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
  end

endmodule

// File: rtl/axi_burst_mem_responder.sv
// AXI4 burst slave backed by on-chip RAM: independent write and read FSMs
// sharing one simple dual-port array, configurable read latency.
module axi_burst_mem_responder
  import axi_resp_pkg::*;
#(
  parameter int unsigned            ID_WIDTH       = 1,
  parameter int unsigned            DATA_WIDTH     = 64,
  parameter int unsigned            ADDR_WIDTH     = 32,
  parameter int unsigned            MEM_DEPTH_LOG2 = 16,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR      = 32'h1000_0000,
  parameter int unsigned            RD_LATENCY     = 2
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESET,
  input  logic [ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]              S_AXI_AWLEN,
  input  logic [2:0]              S_AXI_AWSIZE,
  input  logic [1:0]              S_AXI_AWBURST,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WLAST,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]              S_AXI_ARLEN,
  input  logic [2:0]              S_AXI_ARSIZE,
  input  logic [1:0]              S_AXI_ARBURST,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [ID_WIDTH-1:0]     S_AXI_RID,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RLAST,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY
);

  localparam int unsigned BYTES    = DATA_WIDTH/8;
  localparam int unsigned LSB      = $clog2(BYTES);
  localparam int unsigned WIN_LOG2 = LSB + MEM_DEPTH_LOG2;

  // Base is window-aligned, so the low address bits are already the offset.
  function automatic logic [MEM_DEPTH_LOG2-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
    return addr[LSB +: MEM_DEPTH_LOG2];
  endfunction

  function automatic resp_t burst_resp(input logic [ADDR_WIDTH-1:0] addr,
                                       input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] offset;
    offset = addr - BASE_ADDR;
    if ((offset >> WIN_LOG2) != '0) return RESP_DECERR;
    if (size != 3'(LSB) || burst == BURST_WRAP) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  // Holds both ready outputs low while reset is asserted and for one cycle after.
  logic run;
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) run <= 1'b0;
    else              run <= 1'b1;
  end

  // ---------------- write channel ----------------
  w_state_t              w_state, w_next;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len, w_cnt;
  burst_t                w_burst;
  resp_t                 w_resp;
  logic                  w_last;
  logic [BYTES-1:0]      ram_strb;

  assign w_last = (w_cnt == w_len);

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) w_state <= W_IDLE;
    else              w_state <= w_next;
  end

  always_comb begin
    w_next        = w_state;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        S_AXI_AWREADY = run;
        if (S_AXI_AWVALID && run) w_next = W_DATA;
      end
      W_DATA: begin
        S_AXI_WREADY = 1'b1;
        if (S_AXI_WVALID && w_last) w_next = W_RESP;
      end
      W_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_burst <= BURST_FIXED;
      w_resp  <= RESP_OKAY;
    end else begin
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        w_id    <= S_AXI_AWID;
        w_addr  <= S_AXI_AWADDR;
        w_len   <= S_AXI_AWLEN;
        w_cnt   <= '0;
        w_burst <= burst_t'(S_AXI_AWBURST);
        w_resp  <= burst_resp(S_AXI_AWADDR, S_AXI_AWSIZE, S_AXI_AWBURST);
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        w_cnt <= w_cnt + 8'd1;
        if (w_burst != BURST_FIXED) w_addr <= w_addr + ADDR_WIDTH'(BYTES);
        if (S_AXI_WLAST != w_last && w_resp != RESP_DECERR) w_resp <= RESP_SLVERR;
      end
    end
  end

  assign ram_strb    = (S_AXI_WVALID && S_AXI_WREADY && w_resp != RESP_DECERR) ? S_AXI_WSTRB : '0;
  assign S_AXI_BID   = w_id;
  assign S_AXI_BRESP = w_resp;

  // ---------------- read channel ----------------
  r_state_t              r_state, r_next;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr, r_addr_next;
  logic [7:0]            r_len, r_cnt;
  logic [3:0]            r_wait;
  burst_t                r_burst;
  resp_t                 r_resp;
  logic                  rd_en;
  logic [MEM_DEPTH_LOG2-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign r_addr_next = (r_burst == BURST_FIXED) ? r_addr : r_addr + ADDR_WIDTH'(BYTES);

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) r_state <= R_IDLE;
    else              r_state <= r_next;
  end

  // The RAM read is issued one cycle ahead of each beat so the registered
  // output already holds the word when RVALID is (re)presented.
  always_comb begin
    r_next        = r_state;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    rd_en         = 1'b0;
    rd_addr       = word_index(r_addr);
    unique case (r_state)
      R_IDLE: begin
        S_AXI_ARREADY = run;
        if (S_AXI_ARVALID && run) begin
          if (RD_LATENCY == 0) begin
            r_next  = R_DATA;
            rd_en   = 1'b1;
            rd_addr = word_index(S_AXI_ARADDR);
          end else begin
            r_next = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (r_wait == 4'(RD_LATENCY - 1)) begin
          r_next = R_DATA;
          rd_en  = 1'b1;
        end
      end
      R_DATA: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY) begin
          if (r_cnt == r_len) begin
            r_next = R_IDLE;
          end else begin
            rd_en   = 1'b1;
            rd_addr = word_index(r_addr_next);
          end
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_wait  <= '0;
      r_burst <= BURST_FIXED;
      r_resp  <= RESP_OKAY;
    end else begin
      if (S_AXI_ARVALID && S_AXI_ARREADY) begin
        r_id    <= S_AXI_ARID;
        r_addr  <= S_AXI_ARADDR;
        r_len   <= S_AXI_ARLEN;
        r_cnt   <= '0;
        r_wait  <= '0;
        r_burst <= burst_t'(S_AXI_ARBURST);
        r_resp  <= burst_resp(S_AXI_ARADDR, S_AXI_ARSIZE, S_AXI_ARBURST);
      end
      if (r_state == R_WAIT) r_wait <= r_wait + 4'd1;
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        r_cnt  <= r_cnt + 8'd1;
        r_addr <= r_addr_next;
      end
    end
  end

  assign S_AXI_RID   = r_id;
  assign S_AXI_RRESP = r_resp;
  assign S_AXI_RLAST = S_AXI_RVALID && (r_cnt == r_len);
  assign S_AXI_RDATA = (S_AXI_RVALID && r_resp != RESP_DECERR) ? ram_rdata : '0;

  axi_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (MEM_DEPTH_LOG2)
  ) u_ram (
    .clk     (S_AXI_ACLK),
    .wr_addr (word_index(w_addr)),
    .wr_data (S_AXI_WDATA),
    .wr_strb (ram_strb),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (ram_rdata)
  );

endmodule

// File: tb/tb_axi_burst_mem_responder.sv
// Directed + randomized bench for axi_burst_mem_responder against a
// word-indexed associative-array memory model with per-byte validity.
module tb_axi_burst_mem_responder;

  localparam int          LAT  = 2;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam longint      WIN  = 64'd524288;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [0:0]  awid = '0, bid, arid = '0, rid;
  logic [31:0] awaddr = '0, araddr = '0;
  logic [7:0]  awlen = '0, arlen = '0, wstrb = '0;
  logic [2:0]  awsize = '0, arsize = '0;
  logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
  logic        awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
  logic        bvalid, bready = 1'b0, arvalid = 1'b0, arready;
  logic        rlast, rvalid, rready = 1'b0;
  logic [63:0] wdata = '0, rdata;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] mdata [int unsigned];
  logic [63:0] mmask [int unsigned];
  logic [63:0] wq [$];
  logic [7:0]  sq [$];

  always #5 clk = ~clk;

  axi_burst_mem_responder #(
    .ID_WIDTH       (1),
    .DATA_WIDTH     (64),
    .ADDR_WIDTH     (32),
    .MEM_DEPTH_LOG2 (16),
    .BASE_ADDR      (BASE),
    .RD_LATENCY     (LAT)
  ) dut (
    .S_AXI_ACLK    (clk),     .S_AXI_ARESET  (rst),
    .S_AXI_AWID    (awid),    .S_AXI_AWADDR  (awaddr),  .S_AXI_AWLEN   (awlen),
    .S_AXI_AWSIZE  (awsize),  .S_AXI_AWBURST (awburst), .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready), .S_AXI_WDATA   (wdata),   .S_AXI_WSTRB   (wstrb),
    .S_AXI_WLAST   (wlast),   .S_AXI_WVALID  (wvalid),  .S_AXI_WREADY  (wready),
    .S_AXI_BID     (bid),     .S_AXI_BRESP   (bresp),   .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),  .S_AXI_ARID    (arid),    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARLEN   (arlen),   .S_AXI_ARSIZE  (arsize),  .S_AXI_ARBURST (arburst),
    .S_AXI_ARVALID (arvalid), .S_AXI_ARREADY (arready), .S_AXI_RID     (rid),
    .S_AXI_RDATA   (rdata),   .S_AXI_RRESP   (rresp),   .S_AXI_RLAST   (rlast),
    .S_AXI_RVALID  (rvalid),  .S_AXI_RREADY  (rready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_resp(input logic [31:0] addr, input logic [2:0] size,
                                          input logic [1:0] burst);
    longint a = longint'(addr);
    if (a < longint'(BASE) || a >= longint'(BASE) + WIN) return 2'b11;
    if (size != 3'd3 || burst == 2'b10) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int unsigned beat_word(input logic [31:0] addr, input logic [1:0] burst,
                                            input int unsigned k);
    int unsigned w;
    w = addr - BASE;
    w = w / 8;
    if (burst != 2'b00) w = w + k;
    return w % 65536;
  endfunction

  task automatic model_write(input int unsigned wi, input logic [63:0] d, input logic [7:0] s);
    logic [63:0] md, mm;
    md = mdata.exists(wi) ? mdata[wi] : 64'd0;
    mm = mmask.exists(wi) ? mmask[wi] : 64'd0;
    for (int b = 0; b < 8; b++) begin
      if (s[b]) begin
        md[b*8 +: 8] = d[b*8 +: 8];
        mm[b*8 +: 8] = 8'hFF;
      end
    end
    mdata[wi] = md;
    mmask[wi] = mm;
  endtask

  // Data comes from wq/sq; bad_last withholds WLAST for the whole burst.
  task automatic axi_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst, input logic id, input bit bad_last,
                           input string tag);
    int t;
    logic [1:0] er;
    er = exp_resp(addr, size, burst);
    if (bad_last && er != 2'b11) er = 2'b10;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 200) begin @(negedge clk); t++; end
    check({tag, " awready"}, awready, 1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      wvalid = 1'b1; wdata = wq[k]; wstrb = sq[k];
      wlast = bad_last ? 1'b0 : (k == len);
      t = 0;
      while (!wready && t < 200) begin @(negedge clk); t++; end
      check({tag, " wready"}, wready, 1);
      if (er != 2'b11) model_write(beat_word(addr, burst, k), wq[k], sq[k]);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    check({tag, " bvalid_timing"}, bvalid, 1);
    check({tag, " bresp"}, bresp, er);
    check({tag, " bid"}, bid, id);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check({tag, " bvalid_clear"}, bvalid, 0);
  endtask

  // rmode: 0 RREADY held high, 1 toggling 1/0, 2 random. abort_at >= 0 resets mid-burst.
  task automatic axi_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                          input logic [1:0] burst, input logic id, input int rmode,
                          input int abort_at, input string tag);
    int t, k;
    bit ph;
    int unsigned wi;
    logic [1:0] er;
    er = exp_resp(addr, size, burst);
    @(negedge clk);
    arid = id; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 200) begin @(negedge clk); t++; end
    check({tag, " arready"}, arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    t = 0;
    while (!rvalid && t < 50) begin t++; @(negedge clk); end
    check({tag, " latency"}, 64'(t), 64'(LAT));
    k = 0; ph = 1'b0; t = 0;
    while (k <= len && t < 3000) begin
      rready = (rmode == 0) ? 1'b1 : (rmode == 1) ? !ph : 1'($urandom_range(0, 1));
      ph = !ph;
      if (rvalid && k == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        check({tag, " rvalid_after_reset"}, rvalid, 0);
        check({tag, " arready_in_reset"}, arready, 0);
        rready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (rvalid) begin
        wi = beat_word(addr, burst, k);
        if (er == 2'b11) check({tag, " rdata_decerr"}, rdata, 0);
        else if (mdata.exists(wi)) check({tag, " rdata"}, rdata & mmask[wi], mdata[wi] & mmask[wi]);
        check({tag, " rresp"}, rresp, er);
        check({tag, " rid"}, rid, id);
        check({tag, " rlast"}, rlast, (k == len));
        if (rready) k++;
      end else begin
        check({tag, " rvalid_gap"}, rvalid, 1);
      end
      @(negedge clk);
      t++;
    end
    rready = 1'b0;
    check({tag, " beats"}, 64'(k), 64'(len + 1));
    check({tag, " rvalid_end"}, rvalid, 0);
  endtask

  task automatic fill(input int len, input bit seq, input bit rnd_strb);
    wq.delete(); sq.delete();
    for (int k = 0; k <= len; k++) begin
      wq.push_back(seq ? 64'(k) : {$urandom, $urandom});
      sq.push_back(rnd_strb ? 8'($urandom_range(0, 255)) : 8'hFF);
    end
  endtask

  initial begin
    logic [31:0] a;
    int len;
    logic [1:0] bt;

    repeat (3) @(negedge clk);
    check("reset awready", awready, 0);
    check("reset arready", arready, 0);
    check("reset wready", wready, 0);
    check("reset bvalid", bvalid, 0);
    check("reset rvalid", rvalid, 0);
    check("reset rdata", rdata, 0);
    check("reset rlast", rlast, 0);
    check("reset bresp", bresp, 0);
    check("reset rresp", rresp, 0);
    rst = 1'b0;

    fill(15, 1, 0);
    axi_write(BASE, 15, 3'd3, 2'b01, 1'b1, 0, "incr16_wr");
    axi_read(BASE, 15, 3'd3, 2'b01, 1'b1, 0, -1, "incr16_rd");
    axi_read(BASE + 32'h20, 3, 3'd3, 2'b01, 1'b0, 1, -1, "stall4_rd");

    wq = '{64'hFFFF_FFFF_FFFF_FFFF}; sq = '{8'hFF};
    axi_write(BASE + 32'h100, 0, 3'd3, 2'b01, 1'b0, 0, "strb_pre");
    wq = '{{$urandom, $urandom}}; sq = '{8'h0F};
    axi_write(BASE + 32'h100, 0, 3'd3, 2'b01, 1'b1, 0, "strb_wr");
    axi_read(BASE + 32'h100, 0, 3'd3, 2'b01, 1'b1, 0, -1, "strb_rd");

    fill(1, 0, 0);
    axi_write(32'h0000_0000, 1, 3'd3, 2'b01, 1'b0, 0, "decerr_wr");
    axi_read(BASE, 1, 3'd3, 2'b01, 1'b0, 0, -1, "decerr_untouched");
    axi_read(32'h0000_0000, 1, 3'd3, 2'b01, 1'b1, 0, -1, "decerr_rd");

    fill(1, 0, 0);
    axi_write(BASE + 32'h200, 1, 3'd2, 2'b01, 1'b0, 0, "size_wr");
    fill(3, 0, 0);
    axi_write(BASE + 32'h300, 3, 3'd3, 2'b10, 1'b1, 0, "wrap_wr");
    axi_read(BASE + 32'h300, 3, 3'd3, 2'b01, 1'b0, 2, -1, "wrap_as_incr_rd");
    axi_read(BASE + 32'h300, 3, 3'd3, 2'b10, 1'b1, 0, -1, "wrap_rd");
    fill(2, 0, 0);
    axi_write(BASE + 32'h380, 2, 3'd3, 2'b01, 1'b0, 1, "wlast_wr");

    fill(3, 0, 0);
    axi_write(BASE + 32'h400, 3, 3'd3, 2'b00, 1'b1, 0, "fixed_wr");
    axi_read(BASE + 32'h400, 3, 3'd3, 2'b00, 1'b1, 1, -1, "fixed_rd");
    axi_read(BASE + 32'h408, 0, 3'd3, 2'b01, 1'b0, 0, -1, "fixed_neighbour");

    fill(1, 0, 0);
    axi_write(BASE + 32'h7_FFF8, 1, 3'd3, 2'b01, 1'b0, 0, "modwrap_wr");
    axi_read(BASE + 32'h7_FFF8, 1, 3'd3, 2'b01, 1'b1, 0, -1, "modwrap_rd");

    for (int i = 0; i < 6; i++) begin
      a   = BASE + 32'h1000 + 32'($urandom_range(0, 63)) * 32'd8;
      len = $urandom_range(0, 20);
      bt  = 2'($urandom_range(0, 1));
      fill(len, 0, 1);
      axi_write(a, len, 3'd3, bt, 1'($urandom_range(0, 1)), 0, "rand_wr");
      axi_read(a, len, 3'd3, bt, 1'($urandom_range(0, 1)), 2, -1, "rand_rd");
    end

    axi_read(BASE, 15, 3'd3, 2'b01, 1'b1, 0, 5, "abort_rd");
    axi_read(BASE, 15, 3'd3, 2'b01, 1'b0, 0, -1, "post_reset_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
